// File: rtl/bit_line_monitor.sv
// Single-bit line monitor: edge pulses, saturating toggle/hold counters, stuck and short-hold flags.
// Optional two-flop input synchronizer enabled by defining BIT_LINE_MON_SYNC_EN.
module bit_line_monitor #(
    parameter int CNT_W       = 16,
    parameter int STUCK_LIMIT = 50,
    parameter int MIN_HOLD    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             clear_counts,
    input  logic             line_in,
    output logic             change_pulse,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] toggle_count,
    output logic [CNT_W-1:0] last_hold,
    output logic             stuck,
    output logic             short_hold
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_TRACK = 2'd2,
        ST_STUCK = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] STUCK_LIM_C = CNT_W'(STUCK_LIMIT);
    localparam logic [CNT_W-1:0] MIN_HOLD_C  = CNT_W'(MIN_HOLD);

    logic s;

`ifdef BIT_LINE_MON_SYNC_EN
    logic sync1_q, sync2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= line_in;
            sync2_q <= sync1_q;
        end
    end

    assign s = sync2_q;
`else
    assign s = line_in;
`endif

    state_e           state_q, state_d;
    logic             prev_q, prev_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [CNT_W-1:0] toggle_q, toggle_d;
    logic [CNT_W-1:0] last_hold_q, last_hold_d;
    logic             short_q, short_d;
    logic             change_q, change_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    // NOTE: every variable gets its hold value first, so no path through the
    // case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        hold_cnt_d  = hold_cnt_q;
        toggle_d    = toggle_q;
        last_hold_d = last_hold_q;
        short_d     = short_q;
        change_d    = 1'b0;
        rise_d      = 1'b0;
        fall_d      = 1'b0;

        // Clear is applied before any change evaluation in the same cycle.
        if (clear_counts) begin
            toggle_d = '0;
            short_d  = 1'b0;
        end

        if (!enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_ARM;
                end
                ST_ARM: begin
                    prev_d     = s;
                    hold_cnt_d = CNT_ONE;
                    state_d    = ST_TRACK;
                end
                ST_TRACK, ST_STUCK: begin
                    if (s != prev_q) begin
                        change_d    = 1'b1;
                        rise_d      = s;
                        fall_d      = ~s;
                        if (toggle_d != CNT_MAX) begin
                            toggle_d = toggle_d + CNT_ONE;
                        end
                        last_hold_d = hold_cnt_q;
                        if (hold_cnt_q < MIN_HOLD_C) begin
                            short_d = 1'b1;
                        end
                        hold_cnt_d  = CNT_ONE;
                        prev_d      = s;
                        state_d     = ST_TRACK;
                    end else begin
                        if (hold_cnt_q != CNT_MAX) begin
                            hold_cnt_d = hold_cnt_q + CNT_ONE;
                        end
                        if (hold_cnt_d >= STUCK_LIM_C) begin
                            state_d = ST_STUCK;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            prev_q      <= 1'b0;
            hold_cnt_q  <= '0;
            toggle_q    <= '0;
            last_hold_q <= '0;
            short_q     <= 1'b0;
            change_q    <= 1'b0;
            rise_q      <= 1'b0;
            fall_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            hold_cnt_q  <= hold_cnt_d;
            toggle_q    <= toggle_d;
            last_hold_q <= last_hold_d;
            short_q     <= short_d;
            change_q    <= change_d;
            rise_q      <= rise_d;
            fall_q      <= fall_d;
        end
    end

    assign change_pulse = change_q;
    assign rise_pulse   = rise_q;
    assign fall_pulse   = fall_q;
    assign toggle_count = toggle_q;
    assign last_hold    = last_hold_q;
    assign stuck        = (state_q == ST_STUCK);
    assign short_hold   = short_q;

endmodule

// File: tb/tb_bit_line_monitor.sv
// Scoreboard bench for bit_line_monitor: a stimulus-side model pushes the expected
// event for every line change; a negedge monitor pops and compares on each change_pulse.
module tb_bit_line_monitor;

    localparam int CNT_W       = 16;
    localparam int STUCK_LIMIT = 50;
    localparam int MIN_HOLD    = 2;
`ifdef BIT_LINE_MON_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             enable = 1'b0;
    logic             clear_counts = 1'b0;
    logic             line_in = 1'b0;
    logic             change_pulse, rise_pulse, fall_pulse, stuck, short_hold;
    logic [CNT_W-1:0] toggle_count, last_hold;

    typedef struct {
        logic             rise;
        logic [CNT_W-1:0] tog;
        logic [CNT_W-1:0] last;
        logic             short_f;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_pulses = 0;

    // Stimulus-side expectation state
    logic             m_active = 1'b0;
    logic             m_prev   = 1'b0;
    logic             m_short  = 1'b0;
    logic [CNT_W-1:0] m_hold   = '0;
    logic [CNT_W-1:0] m_tog    = '0;
    logic [CNT_W-1:0] m_last   = '0;

    bit_line_monitor #(
        .CNT_W      (CNT_W),
        .STUCK_LIMIT(STUCK_LIMIT),
        .MIN_HOLD   (MIN_HOLD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .clear_counts(clear_counts),
        .line_in     (line_in),
        .change_pulse(change_pulse),
        .rise_pulse  (rise_pulse),
        .fall_pulse  (fall_pulse),
        .toggle_count(toggle_count),
        .last_hold   (last_hold),
        .stuck       (stuck),
        .short_hold  (short_hold)
    );

    always #10 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    always @(negedge clk) begin
        exp_t e;
        if (change_pulse) begin
            n_pulses++;
            n_checks++;
            if (sb_q.size() == 0) begin
                $display("FAIL unexpected_pulse: change_pulse=1 rise=%b fall=%b at %0t, expected no change",
                         rise_pulse, fall_pulse, $time);
            end else begin
                e = sb_q.pop_front();
                if (rise_pulse !== e.rise || fall_pulse !== ~e.rise || toggle_count !== e.tog ||
                    last_hold !== e.last || short_hold !== e.short_f) begin
                    $display("FAIL sb_event at %0t: got rise=%b fall=%b tog=%0d last=%0d short=%b, expected rise=%b fall=%b tog=%0d last=%0d short=%b",
                             $time, rise_pulse, fall_pulse, toggle_count, last_hold, short_hold,
                             e.rise, ~e.rise, e.tog, e.last, e.short_f);
                end else begin
                    n_pass++;
                end
            end
        end else if (rise_pulse || fall_pulse) begin
            n_checks++;
            $display("FAIL stray_edge_pulse: rise=%b fall=%b without change_pulse at %0t",
                     rise_pulse, fall_pulse, $time);
        end
    end

    // One clock: drive at negedge, update expectations, return 1 ns after the posedge.
    task automatic step(input logic v, input logic clr = 1'b0);
        exp_t e;
        @(negedge clk);
        line_in      = v;
        clear_counts = clr;
        if (clr) begin
            m_tog   = '0;
            m_short = 1'b0;
        end
        if (m_active) begin
            if (v !== m_prev) begin
                if (m_tog != '1) m_tog++;
                if (m_hold < MIN_HOLD) m_short = 1'b1;
                m_last    = m_hold;
                e.rise    = v;
                e.tog     = m_tog;
                e.last    = m_hold;
                e.short_f = m_short;
                sb_q.push_back(e);
                m_hold = 1;
                m_prev = v;
            end else if (m_hold != '1) begin
                m_hold++;
            end
        end
        @(posedge clk);
        #1;
        clear_counts = 1'b0;
    endtask

    task automatic hold(input logic v, input int n);
        for (int i = 0; i < n; i++) step(v);
    endtask

    task automatic arm();
        @(negedge clk);
        enable = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        m_active = 1'b1;
        m_prev   = line_in;
        m_hold   = 1;
    endtask

    task automatic disarm();
        @(negedge clk);
        enable   = 1'b0;
        m_active = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int k = 0;
        while (sb_q.size() != 0 && k < LAT + 4) begin
            step(line_in);
            k++;
        end
        n_checks++;
        if (sb_q.size() != 0) begin
            $display("FAIL drain_%s: %0d expected events never seen, required 0", name, sb_q.size());
            sb_q.delete();
        end else begin
            n_pass++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        enable = 1'b0;
        line_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({change_pulse, rise_pulse, fall_pulse, stuck, short_hold} !== 5'b0 ||
            toggle_count !== '0 || last_hold !== '0) begin
            $display("FAIL reset_state: pulses=%b%b%b stuck=%b short=%b tog=%0d last=%0d, required all 0",
                     change_pulse, rise_pulse, fall_pulse, stuck, short_hold, toggle_count, last_hold);
        end else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        hold(1'b1, 2);
        hold(1'b0, 2);
        hold(1'b1, 2);
        hold(1'b0, 3);
        n_checks++;
        if (toggle_count !== '0) begin
            $display("FAIL idle_frozen: toggle_count=%0d while disabled, required 0", toggle_count);
        end else n_pass++;
    endtask

    task automatic test_basic();
        int p0;
        hold(1'b0, 4);
        arm();
        p0 = n_pulses;
        hold(1'b0, 5);
        hold(1'b1, 5);
        hold(1'b0, 5);
        hold(1'b1, 5);
        drain("basic");
        n_checks++;
        if (toggle_count !== 16'd3 || last_hold !== 16'd5 || short_hold !== 1'b0) begin
            $display("FAIL basic_counts: tog=%0d last=%0d short=%b, required tog=3 last=5 short=0",
                     toggle_count, last_hold, short_hold);
        end else n_pass++;
        n_checks++;
        if (n_pulses - p0 != 3) begin
            $display("FAIL basic_pulse_count: saw %0d change pulses, required 3", n_pulses - p0);
        end else n_pass++;
    endtask

    task automatic test_stuck();
        hold(1'b0, 5);
        step(1'b1);
        for (int i = 1; i <= 59; i++) begin
            step(1'b1);
            if (i == 48 + LAT) begin
                n_checks++;
                if (stuck !== 1'b0) $display("FAIL stuck_early: stuck=%b 48 cycles after pulse, required 0", stuck);
                else n_pass++;
            end
            if (i == 49 + LAT) begin
                n_checks++;
                if (stuck !== 1'b1) $display("FAIL stuck_rise: stuck=%b 49 cycles after pulse, required 1", stuck);
                else n_pass++;
            end
        end
        step(1'b0);
        drain("stuck");
        n_checks++;
        if (stuck !== 1'b0 || last_hold !== 16'd60 || toggle_count !== 16'd6) begin
            $display("FAIL stuck_release: stuck=%b last=%0d tog=%0d, required stuck=0 last=60 tog=6",
                     stuck, last_hold, toggle_count);
        end else n_pass++;
    endtask

    task automatic test_glitch();
        hold(1'b0, 5);
        step(1'b1);
        step(1'b0);
        hold(1'b0, 3);
        drain("glitch");
        n_checks++;
        if (last_hold !== 16'd1 || short_hold !== 1'b1) begin
            $display("FAIL glitch: last=%0d short=%b, required last=1 short=1", last_hold, short_hold);
        end else n_pass++;
        hold(1'b0, 10);
        n_checks++;
        if (short_hold !== 1'b1) $display("FAIL short_sticky: short=%b, required 1", short_hold);
        else n_pass++;
        step(1'b0, 1'b1);
        step(1'b0);
        n_checks++;
        if (short_hold !== 1'b0 || toggle_count !== '0) begin
            $display("FAIL clear_counts: short=%b tog=%0d, required short=0 tog=0", short_hold, toggle_count);
        end else n_pass++;
    endtask

    task automatic test_clear_with_change();
        for (int k = 0; k < 5; k++) hold((k % 2 == 0) ? 1'b1 : 1'b0, 3);
        step(1'b0);
        step(1'b1);
        hold(1'b1, 3);
        drain("pre_clear");
        n_checks++;
        if (toggle_count !== 16'd7 || short_hold !== 1'b1) begin
            $display("FAIL pre_clear: tog=%0d short=%b, required tog=7 short=1", toggle_count, short_hold);
        end else n_pass++;
        step(1'b0, 1'b1);
        hold(1'b0, 2);
        drain("clear_change");
        n_checks++;
        if (toggle_count !== 16'd1 || short_hold !== 1'b0) begin
            $display("FAIL clear_with_change: tog=%0d short=%b, required tog=1 short=0", toggle_count, short_hold);
        end else n_pass++;
    endtask

    task automatic test_reenable();
        int p0;
        disarm();
        hold(1'b1, 3);
        p0 = n_pulses;
        arm();
        hold(1'b1, 5);
        n_checks++;
        if (n_pulses != p0) $display("FAIL enable_no_pulse: saw %0d pulses, required 0", n_pulses - p0);
        else n_pass++;
        hold(1'b1, 50);
        n_checks++;
        if (stuck !== 1'b1) $display("FAIL reenable_stuck: stuck=%b after long hold, required 1", stuck);
        else n_pass++;
        disarm();
        n_checks++;
        if (stuck !== 1'b0 || toggle_count !== m_tog || last_hold !== m_last) begin
            $display("FAIL disable_retain: stuck=%b tog=%0d last=%0d, required stuck=0 tog=%0d last=%0d",
                     stuck, toggle_count, last_hold, m_tog, m_last);
        end else n_pass++;
        arm();
        hold(1'b1, 4);
        n_checks++;
        if (n_pulses != p0 || toggle_count !== m_tog) begin
            $display("FAIL reenable_retain: pulses=%0d tog=%0d, required pulses=0 tog=%0d",
                     n_pulses - p0, toggle_count, m_tog);
        end else n_pass++;
    endtask

    task automatic test_reset_mid();
        step(1'b1, 1'b1);
        hold(1'b0, 3);
        hold(1'b1, 3);
        hold(1'b0, 3);
        hold(1'b1, 3);
        drain("pre_reset");
        n_checks++;
        if (toggle_count !== 16'd4) $display("FAIL pre_reset: tog=%0d, required 4", toggle_count);
        else n_pass++;
        hold(1'b1, 2);
        @(negedge clk);
        rst      = 1'b1;
        enable   = 1'b0;
        line_in  = 1'b0;
        m_active = 1'b0;
        m_tog    = '0;
        m_short  = 1'b0;
        m_last   = '0;
        m_prev   = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if ({change_pulse, rise_pulse, fall_pulse, stuck, short_hold} !== 5'b0 ||
            toggle_count !== '0 || last_hold !== '0) begin
            $display("FAIL reset_mid: pulses=%b%b%b stuck=%b short=%b tog=%0d last=%0d, required all 0",
                     change_pulse, rise_pulse, fall_pulse, stuck, short_hold, toggle_count, last_hold);
        end else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        hold(1'b0, 2);
        arm();
        hold(1'b0, 3);
        step(1'b1);
        hold(1'b1, 3);
        drain("post_reset");
        n_checks++;
        if (toggle_count !== 16'd1) $display("FAIL post_reset_count: tog=%0d, required 1", toggle_count);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stuck();
        test_glitch();
        test_clear_with_change();
        test_reenable();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
